// File: rtl/axidma_rd_req_gen.sv
// AXI DMA read-request generator: splits a byte-addressed transfer into
// AXI read bursts honouring the burst limit, 4 KB boundaries and an outstanding cap.
module axidma_rd_req_gen #(
    parameter int ADDR_WDTH  = 32,
    parameter int LEN_WDTH   = 32,
    parameter int DATA_WDTH  = 64,
    parameter int MAX_OUTSTD = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 cfg_rsoft_rst,
    input  logic                 cfg_rstart,
    input  logic [ADDR_WDTH-1:0] cfg_raddr,
    input  logic [LEN_WDTH-1:0]  cfg_rlen,
    input  logic [7:0]           cfg_rburst_len,
    input  logic                 cfg_rirq_en,
    input  logic                 cfg_rirq_clr,
    output logic                 cfg_ridle,
    output logic [LEN_WDTH-1:0]  cfg_rd_times,
    output logic                 rirq,
    output logic                 rstart_vld,
    input  logic                 rstart_rdy,
    output logic [ADDR_WDTH-1:0] raddr,
    output logic [7:0]           rburst_len,
    input  logic                 rdone
);

    localparam int BYTES = DATA_WDTH / 8;
    localparam int BIT   = $clog2(BYTES);
    localparam int RW    = LEN_WDTH + 1;
    localparam int OW    = $clog2(MAX_OUTSTD + 1);
    localparam int CW    = (RW > 13) ? RW : 13;
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_REQ,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_start_d;
    logic                  r_armed;
    logic [ADDR_WDTH-1:0]  r_addr;
    logic [RW-1:0]         r_rem;
    logic [7:0]            r_blen_cfg;
    logic [8:0]            r_beats;
    logic [OW-1:0]         r_outstd;
    logic [LEN_WDTH-1:0]   r_rd_times;
    logic                  r_rirq;
    logic [ADDR_WDTH-1:0]  r_raddr;
    logic [7:0]            r_rburst_len;

    logic                  w_rst;
    logic                  w_start;
    logic [RW-1:0]         w_sum;
    logic [RW-1:0]         w_tb;
    logic [12:0]           w_pg_beats;
    logic [12:0]           w_cfg_beats;
    logic [12:0]           w_lim;
    logic [8:0]            w_beats;
    logic                  w_hs;
    logic                  w_dec;
    logic [RW-1:0]         w_rem_next;

    assign w_rst = sys_rst | cfg_rsoft_rst;

    // r_armed blocks a start that was already high when reset released
    assign w_start = cfg_rstart & ~r_start_d & r_armed & (r_state == S_IDLE);

    // Total beats include the leading partial beat from an unaligned start
    assign w_sum = RW'(cfg_rlen) + RW'(cfg_raddr[BIT-1:0]);
    assign w_tb  = (w_sum >> BIT) + RW'(|w_sum[BIT-1:0]);

    assign w_pg_beats  = (13'd4096 - {1'b0, r_addr[11:0]}) >> BIT;
    assign w_cfg_beats = {5'd0, r_blen_cfg} + 13'd1;
    assign w_lim       = (w_cfg_beats < w_pg_beats) ? w_cfg_beats : w_pg_beats;
    assign w_beats     = (CW'(r_rem) < CW'(w_lim)) ? r_rem[8:0] : w_lim[8:0];

    assign w_hs       = (r_state == S_REQ) & rstart_rdy;
    assign w_dec      = rdone & (r_outstd != '0);
    assign w_rem_next = r_rem - RW'(r_beats);

    always_ff @(posedge sys_clk) begin
        if (w_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_CALC;
            end
            S_CALC: begin
                if (r_rem == '0) begin
                    w_next = S_DRAIN;
                end else if (r_outstd < MAX_CNT) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (rstart_rdy) w_next = (w_rem_next == '0) ? S_DRAIN : S_CALC;
            end
            S_DRAIN: begin
                if (r_outstd == '0) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (w_rst) begin
            r_start_d    <= 1'b0;
            r_armed      <= 1'b0;
            r_addr       <= '0;
            r_rem        <= '0;
            r_blen_cfg   <= '0;
            r_beats      <= '0;
            r_outstd     <= '0;
            r_rd_times   <= '0;
            r_rirq       <= 1'b0;
            r_raddr      <= '0;
            r_rburst_len <= '0;
        end else begin
            r_start_d <= cfg_rstart;
            if (!cfg_rstart) r_armed <= 1'b1;

            if (w_start) begin
                r_addr     <= {cfg_raddr[ADDR_WDTH-1:BIT], {BIT{1'b0}}};
                r_blen_cfg <= cfg_rburst_len;
                r_rem      <= w_tb;
                r_rd_times <= '0;
            end

            if ((r_state == S_CALC) && (w_next == S_REQ)) begin
                r_beats      <= w_beats;
                r_raddr      <= r_addr;
                r_rburst_len <= 8'(w_beats - 9'd1);
            end

            if (w_hs) begin
                r_addr     <= r_addr + (ADDR_WDTH'(r_beats) << BIT);
                r_rem      <= w_rem_next;
                r_rd_times <= r_rd_times + LEN_WDTH'(1);
            end

            // A completion arriving with nothing outstanding is dropped
            if (w_hs && !w_dec) begin
                r_outstd <= r_outstd + OW'(1);
            end else if (!w_hs && w_dec) begin
                r_outstd <= r_outstd - OW'(1);
            end

            if ((r_state == S_DRAIN) && (r_outstd == '0) && cfg_rirq_en) begin
                r_rirq <= 1'b1;
            end else if (cfg_rirq_clr) begin
                r_rirq <= 1'b0;
            end
        end
    end

    assign cfg_ridle    = (r_state == S_IDLE);
    assign rstart_vld   = (r_state == S_REQ);
    assign raddr        = r_raddr;
    assign rburst_len   = r_rburst_len;
    assign rirq         = r_rirq;
    assign cfg_rd_times = r_rd_times;

endmodule

// File: doc/axidma_rd_req_gen.md
AXIDMA_RD_REQ_GEN -- requirements
Module: axidma_rd_req_gen

Interface
REQ-001 Parameter ADDR_WDTH, default 32: byte address width.
REQ-002 Parameter LEN_WDTH, default 32: transfer length width, in bytes.
REQ-003 Parameter DATA_WDTH, default 64: AXI data width in bits; power of two, 32..1024. BYTES = DATA_WDTH/8; BIT = log2(BYTES).
REQ-004 Parameter MAX_OUTSTD, default 4: maximum number of accepted but uncompleted bursts, 1..16.
REQ-005 Ports (one clock; reset is synchronous and active-high):
- sys_clk  in  1  sole clock.
- sys_rst  in  1  synchronous reset, active-high.
- cfg_rsoft_rst  in  1  soft reset, synchronous, active-high.
- cfg_rstart  in  1  start; its rising edge is the trigger.
- cfg_raddr  in  ADDR_WDTH  start byte address; any alignment.
- cfg_rlen  in  LEN_WDTH  transfer length in bytes.
- cfg_rburst_len  in  8  maximum AXI burst length minus 1.
- cfg_rirq_en  in  1  interrupt enable.
- cfg_rirq_clr  in  1  interrupt clear pulse.
- cfg_ridle  out  1  high in IDLE.
- cfg_rd_times  out  LEN_WDTH  count of bursts accepted in the current transfer.
- rirq  out  1  sticky completion interrupt.
- rstart_vld  out  1  burst request valid.
- rstart_rdy  in  1  burst request ready.
- raddr  out  ADDR_WDTH  burst start address; always BYTES-aligned.
- rburst_len  out  8  AXI ARLEN (beats minus 1).
- rdone  in  1  one-cycle pulse per completed burst.

Function
REQ-006 Start: cfg_rstart=1 with the previous-cycle value 0, while in IDLE -> latch the aligned start address A = {cfg_raddr[ADDR_WDTH-1:BIT], BIT zeros}, cfg_rburst_len and total beats TB = ceil((cfg_raddr[BIT-1:0] + cfg_rlen)/BYTES). Clear cfg_rd_times. Enter CALC next cycle.
REQ-007 A start edge that occurs outside IDLE is ignored; latched values do not change.
REQ-008 States: IDLE, CALC, REQ, DRAIN.
REQ-009 CALC (one cycle): burst beats B = min(remaining beats, cfg_rburst_len+1, (4096 - addr[11:0])/BYTES). Bursts never cross a 4 KB boundary. Transitions:
- outstanding < MAX_OUTSTD -> REQ.
- otherwise stay in CALC.
REQ-010 REQ: rstart_vld=1; raddr = current address; rburst_len = B-1. All three are held stable until rstart_rdy=1.
REQ-011 On the handshake (vld and rdy both high):
- current address += B*BYTES; remaining -= B; cfg_rd_times += 1; outstanding += 1.
- If remaining is now 0 -> DRAIN, else -> CALC.
- rstart_vld drops in the next cycle.
REQ-012 Latency: start edge at cycle T -> rstart_vld high at T+2. Handshake at cycle H -> next rstart_vld high no earlier than H+2.
REQ-013 Outstanding counter, width clog2(MAX_OUTSTD+1):
- rdone decrements it.
- Handshake and rdone in the same cycle -> no change.
- rdone at 0 is ignored; the counter saturates at 0.
REQ-014 DRAIN: stay until outstanding==0, then enter IDLE. rirq is set on that transition if cfg_rirq_en=1.
REQ-015 cfg_rlen=0: TB=0. CALC goes directly to DRAIN with no request; completion then follows REQ-014.
REQ-016 rirq is cleared by cfg_rirq_clr. If set and clear occur in the same cycle, set wins.
REQ-017 All arithmetic is unsigned. TB and remaining are LEN_WDTH+1 bits wide so there is no overflow at maximum cfg_rlen. Address addition wraps modulo 2^ADDR_WDTH.
REQ-018 cfg_rd_times holds its final value in IDLE until the next accepted start.

Reset
REQ-019 sys_rst=1 or cfg_rsoft_rst=1 at a clock edge applies the following at that edge, with priority over all other activity, including mid-burst:
- state=IDLE, rstart_vld=0, raddr=0, rburst_len=0, cfg_rd_times=0, outstanding=0, rirq=0.
- cfg_ridle=1.
- The start-edge history register is set to 0.
REQ-020 After reset, a start edge is recognised only if cfg_rstart was sampled at 0 for at least one cycle after reset.

Verification
REQ-021 DATA_WDTH=64, addr 0x1000, len 0x200, burst_len 15, rdy=1 -> four requests at 0x1000/0x1080/0x1100/0x1180, each with len 15; cfg_rd_times=4.
REQ-022 addr 0x0FF8, len 16, burst_len 255 -> requests 0x0FF8 len 0, then 0x1000 len 0 (4 KB split).
REQ-023 addr 0x1003, len 8 -> single request 0x1000 len 1 (TB=2).
REQ-024 MAX_OUTSTD=2, 4 bursts, rdone withheld -> exactly 2 handshakes. The third rstart_vld rises 2 cycles after the first rdone. rirq=1 only after the 4th rdone, with cfg_rirq_en=1.
REQ-025 len 0, cfg_rirq_en=1 -> no rstart_vld; rirq=1 and cfg_ridle=1 within 3 cycles of the start edge. rirq_clr and a completion in the same cycle -> rirq stays 1.
REQ-026 cfg_rsoft_rst pulse while rstart_vld=1 and rdy=0 -> next cycle rstart_vld=0, cfg_ridle=1, cfg_rd_times=0. A new start then runs normally from the new cfg_raddr.
